// File: rtl/fdu_heartbeat.sv
// Gray-code heartbeat transmitter for the FPGA watchdog's fdu input.
// Walks the 3-bit Gray sequence, holding each code STEP_CYCLES cycles, with stall and skip-inject controls.
module fdu_heartbeat #(
    parameter int STEP_CYCLES = 100000,
    parameter int CNT_W       = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       stall,
    input  logic       inject,
    output logic [2:0] fdu,
    output logic       lap,
    output logic       active,
    output logic       inject_pend
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STEP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       fdu_q, fdu_d;
    logic             lap_q, lap_d;
    logic             pend_q, pend_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        lap_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                idx_d  = 3'd0;
                pend_d = 1'b0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    pend_d  = 1'b0;
                end else if (stall) begin
                    pend_d = pend_q | inject;
                end else if (cnt_q == CNT_TERM) begin
                    cnt_d = '0;
                    // A consumed request swallows a coincident pulse; otherwise a coincident pulse waits for the next advance.
                    if (pend_q) begin
                        idx_d  = idx_q + 3'd2;
                        pend_d = 1'b0;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        pend_d = inject;
                        lap_d  = (idx_q == 3'd7);
                    end
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    pend_d = pend_q | inject;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = 3'd0;
                pend_d  = 1'b0;
            end
        endcase
        fdu_d = idx_d ^ (idx_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            fdu_q   <= 3'b000;
            lap_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            fdu_q   <= fdu_d;
            lap_q   <= lap_d;
            pend_q  <= pend_d;
        end
    end

    assign fdu         = fdu_q;
    assign lap         = lap_q;
    assign active      = (state_q == RUN);
    assign inject_pend = pend_q;

endmodule

// File: tb/tb_fdu_heartbeat.sv
// Scoreboard bench for fdu_heartbeat: stimulus pushes model predictions, a negedge monitor pops and compares.
module tb_fdu_heartbeat;

    localparam int STEP = 4;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       stall;
    logic       inject;
    logic [2:0] fdu;
    logic       lap;
    logic       active;
    logic       inject_pend;

    fdu_heartbeat #(
        .STEP_CYCLES(STEP),
        .CNT_W      (24)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .stall      (stall),
        .inject     (inject),
        .fdu        (fdu),
        .lap        (lap),
        .active     (active),
        .inject_pend(inject_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [2:0] fdu;
        logic       lap;
        logic       active;
        logic       pend;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    // Reference model: position in the heartbeat sequence and cycles spent on the current code.
    logic [2:0] gray_seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    bit m_run  = 0;
    int m_pos  = 0;
    int m_held = 0;
    bit m_pend = 0;
    bit m_lap  = 0;
    int laps_expected = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (fdu !== mon_e.fdu || lap !== mon_e.lap || active !== mon_e.active
                || inject_pend !== mon_e.pend) begin
                failures++;
                $display("FAIL outputs cyc=%0d fdu/lap/active/pend got=%b/%b/%b/%b want=%b/%b/%b/%b",
                         cyc, fdu, lap, active, inject_pend,
                         mon_e.fdu, mon_e.lap, mon_e.active, mon_e.pend);
            end
        end
    end

    task automatic drive(input bit r, input bit e, input bit s, input bit i);
        exp_t x;
        @(posedge clk);
        #1;
        reset  = r;
        enable = e;
        stall  = s;
        inject = i;
        if (r) begin
            m_run = 0; m_pos = 0; m_held = 0; m_pend = 0; m_lap = 0;
        end else if (!m_run) begin
            m_run = e; m_pos = 0; m_held = 0; m_pend = 0; m_lap = 0;
        end else if (!e) begin
            m_run = 0; m_pos = 0; m_held = 0; m_pend = 0; m_lap = 0;
        end else if (s) begin
            m_lap  = 0;
            m_pend = m_pend | i;
        end else begin
            m_held++;
            m_lap = 0;
            if (m_held == STEP) begin
                m_held = 0;
                if (m_pend) begin
                    m_pos  = (m_pos + 2) % 8;
                    m_pend = 0;
                end else begin
                    m_pos  = (m_pos + 1) % 8;
                    m_lap  = (m_pos == 0);
                    m_pend = i;
                end
            end else begin
                m_pend = m_pend | i;
            end
        end
        if (m_lap) laps_expected++;
        x.due    = cyc + 1;
        x.fdu    = m_run ? gray_seq[m_pos] : 3'b000;
        x.lap    = m_lap;
        x.active = m_run;
        x.pend   = m_pend;
        sb_q.push_back(x);
        $display("txn cyc=%0d rst=%0b en=%0b stall=%0b inj=%0b -> fdu=%03b lap=%0b act=%0b pend=%0b",
                 cyc + 1, r, e, s, i, x.fdu, x.lap, x.active, x.pend);
    endtask

    // Run freely until the model sits at the given code position having just entered it.
    task automatic run_until(input int pos, input string tag);
        int n = 0;
        while (!(m_run && m_pos == pos && m_held == 0) && n < 100) begin
            drive(0, 1, 0, 0);
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL %s wait_budget got=%0d cycles required<100", tag, n);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        stall  = 1'b1;
        inject = 1'b1;

        // Reset with every other control asserted
        repeat (2) drive(1, 1, 1, 1);
        // Free run: two full laps
        repeat (70) drive(0, 1, 0, 0);
        // Stall ten cycles on 011
        run_until(2, "stall_wait");
        repeat (10) drive(0, 1, 1, 0);
        repeat (40) drive(0, 1, 0, 0);
        // Inject on 001, then a second pulse while pending
        run_until(1, "inject_wait");
        drive(0, 1, 0, 1);
        drive(0, 1, 0, 1);
        repeat (40) drive(0, 1, 0, 0);
        // Inject on 101 so the skip wraps to 000 without a lap
        run_until(6, "wrap_wait");
        drive(0, 1, 0, 1);
        repeat (45) drive(0, 1, 0, 0);
        // Inject on 111 then disable, inject in IDLE, re-enable
        run_until(5, "disable_wait");
        drive(0, 1, 0, 1);
        drive(0, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 1);
        repeat (12) drive(0, 1, 0, 0);
        // Inject coinciding with the terminal-count advance
        run_until(3, "coincide_wait");
        repeat (3) drive(0, 1, 0, 0);
        drive(0, 1, 0, 1);
        repeat (10) drive(0, 1, 0, 0);
        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 499) == 0),
                  ($urandom_range(0, 31) != 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 15) == 0));
        end
        drive(0, 1, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d entries required=0", sb_q.size());
        end
        checks++;
        if (laps_expected < 3) begin
            failures++;
            $display("FAIL lap_coverage got=%0d laps required>=3", laps_expected);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fdu_heartbeat.md
Name: fdu_heartbeat

Overview:
- Generates the 3-bit Gray-code heartbeat on `fdu` that the FPGA watchdog monitors. This is the transmitting end of the watchdog's `fdu` interface.
- Steps through 000,001,011,010,110,111,101,100 and wraps to 000. Each code is held for a programmable number of cycles.
- Provides stall and fault-injection controls so the bench and system software can deliberately starve or corrupt the heartbeat and exercise the watchdog's unhealthy path.

Parameters:
- STEP_CYCLES, 100000: clk cycles each code is held. Legal range 2..2^CNT_W-1. Default lap is 800000 cycles, well inside the 6500000-cycle watchdog timeout.
- CNT_W, 24: width of the step counter.

Ports:
- clk  in  1  system clock. Single clock domain; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level. High = generate heartbeat; low = return to idle.
- stall  in  1  level. High freezes the step counter and holds the current code (simulates hung software).
- inject  in  1  pulse. Requests that the next code advance skip one code (an illegal 2-bit transition).
- fdu  out  3  heartbeat code to the watchdog, registered.
- lap  out  1  one-cycle pulse, registered, on a normal 100->000 wrap.
- active  out  1  high while in RUN.
- inject_pend  out  1  high while an inject request is latched and not yet consumed.

Behaviour:
Clocking and reset
- One clock domain; every output is a flop.
- Reset is synchronous and active-high. At the first posedge with reset=1: state=IDLE, fdu=000, idx=0, step counter=0, lap=0, active=0, inject_pend=0.
- Reset overrides every other input.

Code generation
- Internal 3-bit index idx; fdu = idx ^ (idx>>1), registered together with idx.
- Mapping: 0:000, 1:001, 2:011, 3:010, 4:110, 5:111, 6:101, 7:100.

State machine (2 states)
- IDLE:
  - fdu=000, counter=0, idx=0, active=0.
  - inject is ignored; inject_pend is held at 0.
  - enable=1 sampled -> RUN on the next cycle, with counter=0, idx=0 and active=1.
- RUN, per cycle:
  - enable=0 -> IDLE next cycle: fdu=000, idx=0, counter=0, inject_pend=0, lap=0. The jump to 000 mid-lap may be illegal for the monitor; this is intended.
  - else if stall=1 -> counter, idx, fdu hold; lap=0.
  - else if counter==STEP_CYCLES-1 -> counter=0 and idx advances:
    - normal advance: idx+1 mod 8;
    - if inject_pend=1: idx+2 mod 8, and inject_pend clears.
  - else -> counter+1.
- In RUN, every code is held exactly STEP_CYCLES unstalled cycles, including the first 000 after entry. The stream starts with 000 so the watchdog leaves its IDLE state.

Lap pulse
- lap=1 for exactly the one cycle in which fdu first shows 000 after a normal (non-inject) advance from idx 7.
- An inject skip that wraps does not pulse lap: 6->0 gives 101->000, 7->1 gives 100->001.

Inject rules
- inject=1 in RUN sets inject_pend; it is single-depth, so extra pulses while pending have no effect.
- If inject=1 arrives in the same cycle as an advance that consumes a pending request, the pending request is consumed and the new pulse is dropped.
- If inject=1 arrives in the same cycle as an advance with nothing pending, the request is latched and applies to the following advance, not the current one.
- Stall does not clear inject_pend.

Simultaneous events
- Priority: reset > enable=0 > stall > terminal count.

Widths
- Counter compare is against STEP_CYCLES-1 at CNT_W bits.
- idx arithmetic is mod 8 with natural 3-bit wrap.

Test Plan:
All scenarios use STEP_CYCLES=4.
1. Reset:
   - Stimulus: assert reset 2 cycles with enable=1, stall=1, inject=1.
   - Response: fdu=000, lap=0, active=0, inject_pend=0 throughout; after release, RUN entered one cycle later.
2. Free run:
   - Stimulus: enable=1 from IDLE.
   - Response: active=1 next cycle; fdu holds each of 000,001,011,010,110,111,101,100 for 4 cycles; 000 reappears at cycle 33 with lap=1 for 1 cycle; lap period is 32 cycles.
3. Stall:
   - Stimulus: stall=1 for 10 cycles during fdu=011.
   - Response: 011 is held 14 cycles total, then 010; lap period is 42 cycles for that lap.
4. Inject:
   - Stimulus: inject pulse while fdu=001.
   - Response: inject_pend=1 next cycle; the next code is 010 (011 skipped) and inject_pend=0; then 110 follows normally. A second inject pulse while pending produces only one skip.
5. Inject across wrap:
   - Stimulus: inject while fdu=101.
   - Response: next code 000 with lap=0; the following lap pulses normally.
6. Disable and re-enable:
   - Stimulus: enable=0 while fdu=111 with inject_pend=1, then enable=1 again.
   - Response: next cycle fdu=000, active=0, inject_pend=0. An inject pulse in IDLE does not set inject_pend. After re-enable, 000 is held a full 4 cycles, then 001.
